pll_lock_ctrl: RTL

- Acquisition/lock sequencer in front of the PLL loop filter.
- Takes raw phase-detector up/dn pulses and drives the loop filter's up/dn/rst inputs:
  - full-rate pass-through during acquisition;
  - decimated majority-vote pulses during tracking.
- Declares lock from windowed phase-error statistics.
- Restarts acquisition when the 8-bit filter speed value hits a rail.

---
 rtl/pll_lock_ctrl_pkg.sv | 28 ++
 rtl/pll_err_window.sv | 51 +++++
 rtl/pll_lock_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pll_lock_ctrl_pkg.sv
// Shared definitions for the PLL acquisition/lock sequencer.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package pll_lock_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_ACQ    = 3'd2,
        ST_TRACK  = 3'd3,
        ST_LOCKED = 3'd4
    } state_t;

    localparam logic [7:0] SPEED_MIN = 8'd0;
    localparam logic [7:0] SPEED_MAX = 8'd255;
    localparam logic [7:0] SPEED_MID = 8'd128;

    // Magnitude of a window's net phase error.
    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Loop filter output pinned at either rail means the loop ran away.
    function automatic logic at_rail(input logic [7:0] speed);
        return (speed == SPEED_MIN) || (speed == SPEED_MAX);
    endfunction

endpackage

// File: rtl/pll_err_window.sv
// Windowed net phase-error accumulator (window counter + signed sum).
// Latency: win_end/win_sum are combinational on the current cycle's pd inputs.
// Backpressure: none; advances every cycle unless clear is held.
module pll_err_window #(
    parameter int DECIM = 16,
    parameter int AW    = $clog2(DECIM) + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 pd_up,
    input  logic                 pd_dn,
    output logic                 win_end,
    output logic signed [AW-1:0] win_sum
);

    localparam int CW = $clog2(DECIM);

    logic [CW-1:0]        cnt;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] err;

    // Per-cycle net error: +1 speed up, -1 slow down, 0 when both or neither.
    always_comb begin
        err = '0;
        if (pd_up && !pd_dn) begin
            err = AW'(1);
        end else if (pd_dn && !pd_up) begin
            err = '1;
        end
    end

    assign win_end = !clear && (cnt == CW'(DECIM - 1));
    // The final sum includes the error of the window's last cycle.
    assign win_sum = acc + err;

    // Accumulate within a window; restart from zero at window end or while held clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            acc <= '0;
        end else if (clear || win_end) begin
            cnt <= '0;
            acc <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            acc <= win_sum;
        end
    end

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL acquisition/lock sequencer driving loop-filter up/dn/rst from phase-detector pulses.
// Latency: all outputs registered, one cycle after the deciding input/state.
// Backpressure: none; enable low returns to IDLE on the next cycle.
module pll_lock_ctrl
    import pll_lock_ctrl_pkg::*;
#(
    parameter int DECIM        = 16,
    parameter int ACQ_CYCLES   = 256,
    parameter int LOCK_TOL     = 2,
    parameter int LOCK_WINDOWS = 8,
    parameter int UNLOCK_TOL   = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       pd_up,
    input  logic       pd_dn,
    input  logic [7:0] speed_var,
    output logic       lf_up,
    output logic       lf_dn,
    output logic       lf_rst,
    output logic       locked,
    output logic [2:0] state
);

    localparam int AW  = $clog2(DECIM) + 2;
    localparam int ACW = $clog2(ACQ_CYCLES + 1);
    localparam int GW  = $clog2(LOCK_WINDOWS + 1);

    state_t               state_q, state_d;
    logic [ACW-1:0]       acq_q, acq_d;
    logic [GW-1:0]        good_q, good_d;
    logic                 up_d, dn_d;
    logic                 win_clear;
    logic                 win_end;
    logic signed [AW-1:0] win_sum;
    int                   fin;

    // Window statistics only run while tracking or locked.
    assign win_clear = !((state_q == ST_TRACK) || (state_q == ST_LOCKED));

    pll_err_window #(
        .DECIM (DECIM),
        .AW    (AW)
    ) u_win (
        .clk     (clk),
        .rst     (rst),
        .clear   (win_clear),
        .pd_up   (pd_up),
        .pd_dn   (pd_dn),
        .win_end (win_end),
        .win_sum (win_sum)
    );

    // Sequencing: next state, counters and the next cycle's loop-filter pulses.
    always_comb begin
        state_d = state_q;
        acq_d   = acq_q;
        good_d  = good_q;
        up_d    = 1'b0;
        dn_d    = 1'b0;
        fin     = int'(win_sum);
        case (state_q)
            ST_IDLE: begin
                acq_d  = '0;
                good_d = '0;
                if (enable) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                acq_d   = '0;
                good_d  = '0;
                state_d = ST_ACQ;
            end
            ST_ACQ: begin
                // Full-rate pass-through; conflicting requests cancel out.
                up_d  = pd_up && !pd_dn;
                dn_d  = pd_dn && !pd_up;
                acq_d = acq_q + 1'b1;
                if (int'(acq_q) == ACQ_CYCLES - 1) state_d = ST_TRACK;
            end
            ST_TRACK, ST_LOCKED: begin
                if (win_end) begin
                    if (at_rail(speed_var)) begin
                        // Runaway filter: restart acquisition, suppress this window's pulse.
                        state_d = ST_CLEAR;
                        good_d  = '0;
                    end else begin
                        up_d = (fin > 0);
                        dn_d = (fin < 0);
                        if (state_q == ST_TRACK) begin
                            if (iabs(fin) <= LOCK_TOL) begin
                                good_d = good_q + 1'b1;
                                if (int'(good_q) + 1 >= LOCK_WINDOWS) state_d = ST_LOCKED;
                            end else begin
                                good_d = '0;
                            end
                        end else if (iabs(fin) > UNLOCK_TOL) begin
                            state_d = ST_TRACK;
                            good_d  = '0;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Run request dropped: everything returns to idle regardless of state.
        if (!enable) begin
            state_d = ST_IDLE;
            up_d    = 1'b0;
            dn_d    = 1'b0;
            acq_d   = '0;
            good_d  = '0;
        end
    end

    // State, counters and registered outputs; lf_rst/locked follow the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acq_q   <= '0;
            good_q  <= '0;
            lf_up   <= 1'b0;
            lf_dn   <= 1'b0;
            lf_rst  <= 1'b0;
            locked  <= 1'b0;
        end else begin
            state_q <= state_d;
            acq_q   <= acq_d;
            good_q  <= good_d;
            lf_up   <= up_d;
            lf_dn   <= dn_d;
            lf_rst  <= (state_d == ST_CLEAR);
            locked  <= (state_d == ST_LOCKED);
        end
    end

    assign state = state_q;

endmodule
